pattern_gen: RTL and testbench
==============================

# pattern_gen

Parametrised multi-mode video test-pattern generator for the SDL simulation harness and FPGA video tops. It consumes the sync generator's pixel coordinates and active flag and produces per-pixel RGB at configurable bit depth. Four patterns are selectable: quadrant gamut ramps, 8-bar colour bars, checkerboard and an animated bouncing box. Mode changes are frame-synchronous, so a frame is never torn between patterns.

## Interface

- H_RES, 1024: active pixels per line.
- V_RES, 768: active lines per frame.
- BPC, 8: bits per colour channel, 4..10.
- GRAD_SHIFT, 1: right-shift applied to h for gradient ramps.
- CHECK_LOG2, 5: checker cell size is 2^CHECK_LOG2 pixels.
- BOX_SIZE, 64: bouncing box edge length in pixels.
- AUTO_FRAMES, 120: frames per mode when auto-cycle is compiled in.

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- h  in  13  horizontal pixel coordinate from sync.
- v  in  13  vertical line coordinate from sync.
- active  in  1  sync active-video flag.
- mode_sel  in  2  requested pattern: 0 gamut, 1 bars, 2 checker, 3 box.
- r, g, b  out  BPC each  pixel colour.
- de  out  1  active delayed to align with r/g/b.
- mode_cur  out  2  pattern currently being drawn.

## Operation

- Frame start (fs) is the cycle with h==0 && v==0; all frame-rate state updates only on fs.
- On fs, mode_cur <= mode_sel. A mode_sel change mid-frame takes effect only at the next fs.
- Full scale F = all-ones BPC. Ramp value G = (h >> GRAD_SHIFT), truncated to its BPC LSBs, so it wraps with no saturation.
- Mode 0, gamut: left = h < H_RES/2, top = v < V_RES/2. Top-left (G,0,0), top-right (0,G,0), bottom-left (0,0,G), bottom-right (G,G,G).
- Mode 1, colour bars: bar width W = H_RES/8; H_RES must be a multiple of 8. No divider is used.
  - Bar index comes from a 3-bit counter plus a position counter. Both clear when h==0.
  - The index increments when the position counter reaches W-1 and saturates at 7.
  - Order 0..7: white, yellow, cyan, green, magenta, red, blue, black, each channel F or 0.
- Mode 2, checker: white (F,F,F) when h[CHECK_LOG2] ^ v[CHECK_LOG2] == 1, else black.
- Mode 3, box: position registers x,y (13b) and direction bits dx,dy (1 = increasing).
  - Pixel is white when x <= h < x+BOX_SIZE and y <= v < y+BOX_SIZE, else black.
  - Update on fs, 1 px per axis per frame. If dx and x+BOX_SIZE == H_RES: dx <= 0, x <= x-1. If !dx and x == 0: dx <= 1, x <= 1. Otherwise step in the current direction. Same rule for y against V_RES.
  - Box state advances on every fs regardless of mode_cur.
- Blanking: r/g/b are 0 whenever de is 0.

## Timing

- Two-stage pipeline. Stage 1 registers coordinates, region flags and bar index. Stage 2 registers colour.
- h/v/active presented at cycle N give r/g/b/de at cycle N+2. de is active delayed by exactly 2.
- mode_cur updates the cycle after fs is sampled. The fs pixel itself is drawn in the new mode.
- Reset (async assert, synchronous deassert handled upstream) values:
  - r=g=b=0, de=0, mode_cur=0.
  - x=y=0, dx=dy=1.
  - Bar counters 0, frame counter 0, pipeline valid bits 0.
- Reset asserted mid-frame clears immediately. Output resumes correctly from the next pixel after release. Box restarts at (0,0).

## Configuration

- PATTERN_AUTO_CYCLE_EN defined:
  - A frame counter counts fs events.
  - When it reaches AUTO_FRAMES-1 it clears and mode_cur increments mod 4 on that fs.
  - mode_sel is ignored.
- Undefined: no frame counter is synthesised and mode_cur follows mode_sel at fs.

## Test plan

- Mode 0, BPC=8, h=300, v=100, active=1 -> two cycles later r=0x96, g=0, b=0, de=1. h=900, v=600 -> r=g=b=0xC2.
- Mode 1, H_RES=1024: h=0 -> (F,F,F); h=127 -> white; h=128 -> (F,F,0); h=1023 -> (0,0,0).
- Mode 2, CHECK_LOG2=5: h=32, v=0 -> white; h=32, v=32 -> black; active=0 -> r=g=b=0 and de=0.
- Mode 3 from reset, BOX_SIZE=64: after 960 frame starts x=960 and dx flips to 0; after 961 frame starts x=959. Pixel (h=x, v=y) is white and (h=x+64, v=y) is black.
- Change mode_sel 0->2 at v=300: the rest of the frame stays gamut and the next frame is checker. Assert rst_n=0 mid-line: outputs read 0 in the same cycle.
- With PATTERN_AUTO_CYCLE_EN and AUTO_FRAMES=4: mode_cur goes 0,1,2,3,0 every 4 frame starts independent of mode_sel.

Source files
------------

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - multi-mode video test-pattern generator; PATTERN_AUTO_CYCLE_EN enables frame-count mode cycling
module pattern_gen #(
    parameter int H_RES       = 1024,
    parameter int V_RES       = 768,
    parameter int BPC         = 8,
    parameter int GRAD_SHIFT  = 1,
    parameter int CHECK_LOG2  = 5,
    parameter int BOX_SIZE    = 64,
    parameter int AUTO_FRAMES = 120
) (
    input  logic           clk_pix,
    input  logic           rst_n,
    input  logic [12:0]    h,
    input  logic [12:0]    v,
    input  logic           active,
    input  logic [1:0]     mode_sel,
    output logic [BPC-1:0] r,
    output logic [BPC-1:0] g,
    output logic [BPC-1:0] b,
    output logic           de,
    output logic [1:0]     mode_cur
);
    localparam logic [13:0] H_LIM    = 14'(H_RES);
    localparam logic [13:0] V_LIM    = 14'(V_RES);
    localparam logic [13:0] BOX      = 14'(BOX_SIZE);
    localparam logic [12:0] BAR_LAST = 13'(H_RES / 8 - 1);
    localparam logic [12:0] H_HALF   = 13'(H_RES / 2);
    localparam logic [12:0] V_HALF   = 13'(V_RES / 2);

    logic           fs;
    logic [1:0]     mode_q, mode_d;
    logic [12:0]    x_q, x_d, y_q, y_d;
    logic           dx_q, dx_d, dy_q, dy_d;
    logic [12:0]    pos_q, pos_d, cur_pos;
    logic [2:0]     idx_q, idx_d, cur_idx;
    logic [12:0]    h1_q, h1_d, v1_q, v1_d;
    logic           act1_q, act1_d, left1_q, left1_d, top1_q, top1_d, chk1_q, chk1_d;
    logic [2:0]     bar1_q, bar1_d;
    logic [BPC-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic           de_q, de_d;
    logic [BPC-1:0] ramp;
    logic           in_box;
    logic [2:0]     rgb_on;

`ifdef PATTERN_AUTO_CYCLE_EN
    localparam int         FCW       = $clog2(AUTO_FRAMES) + 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(AUTO_FRAMES - 1);
    logic [FCW-1:0] fcnt_q, fcnt_d;
`endif

    assign fs     = (h == 13'd0) && (v == 13'd0);
    assign ramp   = BPC'(h1_q >> GRAD_SHIFT);
    // Box test uses stage-1 coordinates against post-fs box position, so the whole frame agrees
    assign in_box = (h1_q >= x_q) && ({1'b0, h1_q} < {1'b0, x_q} + BOX) &&
                    (v1_q >= y_q) && ({1'b0, v1_q} < {1'b0, y_q} + BOX);

    always_comb begin
        mode_d = mode_q;
        x_d    = x_q;
        y_d    = y_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
`ifdef PATTERN_AUTO_CYCLE_EN
        fcnt_d = fcnt_q;
        if (fs) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                mode_d = mode_q + 2'd1;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
`else
        if (fs) mode_d = mode_sel;
`endif
        if (fs) begin
            if (dx_q && ({1'b0, x_q} + BOX == H_LIM)) begin
                dx_d = 1'b0;
                x_d  = x_q - 13'd1;
            end else if (!dx_q && x_q == 13'd0) begin
                dx_d = 1'b1;
                x_d  = 13'd1;
            end else begin
                x_d = dx_q ? x_q + 13'd1 : x_q - 13'd1;
            end
            if (dy_q && ({1'b0, y_q} + BOX == V_LIM)) begin
                dy_d = 1'b0;
                y_d  = y_q - 13'd1;
            end else if (!dy_q && y_q == 13'd0) begin
                dy_d = 1'b1;
                y_d  = 13'd1;
            end else begin
                y_d = dy_q ? y_q + 13'd1 : y_q - 13'd1;
            end
        end

        // Counters hold the position of the next pixel; h==0 forces a fresh line
        cur_pos = (h == 13'd0) ? 13'd0 : pos_q;
        cur_idx = (h == 13'd0) ? 3'd0 : idx_q;
        if (cur_pos == BAR_LAST) begin
            pos_d = 13'd0;
            idx_d = (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
        end else begin
            pos_d = cur_pos + 13'd1;
            idx_d = cur_idx;
        end

        h1_d    = h;
        v1_d    = v;
        act1_d  = active;
        left1_d = h < H_HALF;
        top1_d  = v < V_HALF;
        chk1_d  = h[CHECK_LOG2] ^ v[CHECK_LOG2];
        bar1_d  = cur_idx;

        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        rgb_on = 3'b000;
        case (mode_q)
            2'd0: begin
                case ({top1_q, left1_q})
                    2'b11:   r_d = ramp;
                    2'b10:   g_d = ramp;
                    2'b01:   b_d = ramp;
                    default: begin
                        r_d = ramp;
                        g_d = ramp;
                        b_d = ramp;
                    end
                endcase
            end
            2'd1: begin
                case (bar1_q)
                    3'd0:    rgb_on = 3'b111;
                    3'd1:    rgb_on = 3'b110;
                    3'd2:    rgb_on = 3'b011;
                    3'd3:    rgb_on = 3'b010;
                    3'd4:    rgb_on = 3'b101;
                    3'd5:    rgb_on = 3'b100;
                    3'd6:    rgb_on = 3'b001;
                    default: rgb_on = 3'b000;
                endcase
            end
            2'd2:    rgb_on = {3{chk1_q}};
            default: rgb_on = {3{in_box}};
        endcase
        if (mode_q != 2'd0) begin
            r_d = {BPC{rgb_on[2]}};
            g_d = {BPC{rgb_on[1]}};
            b_d = {BPC{rgb_on[0]}};
        end
        if (!act1_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
        de_d = act1_q;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 2'd0;
            x_q     <= 13'd0;
            y_q     <= 13'd0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            pos_q   <= 13'd0;
            idx_q   <= 3'd0;
            h1_q    <= 13'd0;
            v1_q    <= 13'd0;
            act1_q  <= 1'b0;
            left1_q <= 1'b0;
            top1_q  <= 1'b0;
            chk1_q  <= 1'b0;
            bar1_q  <= 3'd0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            de_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            h1_q    <= h1_d;
            v1_q    <= v1_d;
            act1_q  <= act1_d;
            left1_q <= left1_d;
            top1_q  <= top1_d;
            chk1_q  <= chk1_d;
            bar1_q  <= bar1_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            de_q    <= de_d;
        end
    end

`ifdef PATTERN_AUTO_CYCLE_EN
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end
`endif

    assign r        = r_q;
    assign g        = g_q;
    assign b        = b_q;
    assign de       = de_q;
    assign mode_cur = mode_q;
endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - randomized self-checking bench for pattern_gen (default build, PATTERN_AUTO_CYCLE_EN undefined)
module tb_pattern_gen;
    localparam int H_RES = 1024, V_RES = 768, BPC = 8, GRAD_SHIFT = 1;
    localparam int CHECK_LOG2 = 5, BOX_SIZE = 64, AUTO_FRAMES = 120;

    logic           clk_pix = 1'b0;
    logic           rst_n;
    logic [12:0]    h, v;
    logic           active;
    logic [1:0]     mode_sel;
    logic [BPC-1:0] r, g, b;
    logic           de;
    logic [1:0]     mode_cur;

    int checks = 0;
    int errors = 0;

    logic [1:0]     mode_m;
    int             k_m, n_m;
    logic [3*BPC:0] cur_exp, out_exp;

    always #5 clk_pix = ~clk_pix;

    pattern_gen #(
        .H_RES(H_RES), .V_RES(V_RES), .BPC(BPC), .GRAD_SHIFT(GRAD_SHIFT),
        .CHECK_LOG2(CHECK_LOG2), .BOX_SIZE(BOX_SIZE), .AUTO_FRAMES(AUTO_FRAMES)
    ) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .h(h), .v(v), .active(active),
        .mode_sel(mode_sel), .r(r), .g(g), .b(b), .de(de), .mode_cur(mode_cur)
    );

    // Bouncing coordinate after k frame starts is a triangle wave over [0, span]
    function automatic int tri_pos(int k, int span);
        int p;
        p = k % (2 * span);
        return (p <= span) ? p : 2 * span - p;
    endfunction

    function automatic logic [3*BPC:0] model_pix(logic [1:0] mode, int hh, int vv, bit act, int n, int k);
        int full, gr, idx, x, y;
        int rr, gg, bb;
        rr = 0; gg = 0; bb = 0;
        full = (1 << BPC) - 1;
        gr = (hh >> GRAD_SHIFT) % (1 << BPC);
        if (!act) return '0;
        case (mode)
            2'd0: begin
                if (hh < H_RES / 2 && vv < V_RES / 2) rr = gr;
                else if (vv < V_RES / 2) gg = gr;
                else if (hh < H_RES / 2) bb = gr;
                else begin rr = gr; gg = gr; bb = gr; end
            end
            2'd1: begin
                idx = n / (H_RES / 8);
                if (idx > 7) idx = 7;
                rr = (idx inside {0, 1, 4, 5}) ? full : 0;
                gg = (idx inside {0, 1, 2, 3}) ? full : 0;
                bb = (idx inside {0, 2, 4, 6}) ? full : 0;
            end
            2'd2: begin
                if ((((hh >> CHECK_LOG2) ^ (vv >> CHECK_LOG2)) & 1) == 1) begin
                    rr = full; gg = full; bb = full;
                end
            end
            default: begin
                x = tri_pos(k, H_RES - BOX_SIZE);
                y = tri_pos(k, V_RES - BOX_SIZE);
                if (hh >= x && hh < x + BOX_SIZE && vv >= y && vv < y + BOX_SIZE) begin
                    rr = full; gg = full; bb = full;
                end
            end
        endcase
        return {1'b1, rr[BPC-1:0], gg[BPC-1:0], bb[BPC-1:0]};
    endfunction

    task automatic reset_model();
        mode_m = 2'd0; k_m = 0; n_m = -1; cur_exp = '0; out_exp = '0;
    endtask

    // Drives one pixel; afterwards the outputs should show the pixel driven one step earlier
    task automatic step(input int hh, input int vv, input bit act);
        if (hh == 0 && vv == 0) begin
            mode_m = mode_sel;
            k_m++;
        end
        n_m = (hh == 0) ? 0 : n_m + 1;
        out_exp = cur_exp;
        cur_exp = model_pix(mode_m, hh, vv, act, n_m, k_m);
        h = 13'(hh); v = 13'(vv); active = act;
        @(posedge clk_pix); #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; h = 13'd1; v = 13'd1; active = 1'b0;
        repeat (2) @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; h = 13'd1; v = 13'd1; active = 1'b1; mode_sel = 2'd2;
        #2;
        checks++;
        if ({mode_cur, de, r, g, b} !== '0)
            begin errors++; $display("FAIL reset_state got %h exp 0", {mode_cur, de, r, g, b}); end
        repeat (2) @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        reset_model();
        step(7, 3, 1);
        checks++;
        if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
            begin errors++; $display("FAIL reset_first got %h exp %h", {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
    endtask

    task automatic test_gamut();
        mode_sel = 2'd0;
        step(0, 0, 1);
        step(300, 100, 1);
        step(900, 600, 1);
        checks++;
        if ({de, r, g, b} !== 25'h1_960000)
            begin errors++; $display("FAIL gamut_tl got %h exp %h", {de, r, g, b}, 25'h1_960000); end
        step(5, 5, 0);
        checks++;
        if ({de, r, g, b} !== 25'h1_C2C2C2)
            begin errors++; $display("FAIL gamut_br got %h exp %h", {de, r, g, b}, 25'h1_C2C2C2); end
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 1200), $urandom_range(1, 900), $urandom_range(0, 3) != 0);
            checks++;
            if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                begin errors++; $display("FAIL gamut_px got %h exp %h", {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
        end
    endtask

    task automatic test_bars();
        mode_sel = 2'd1;
        step(0, 0, 0);
        for (int hh = 0; hh < 1100; hh++) begin
            step(hh, 1, hh < H_RES);
            checks++;
            if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                begin errors++; $display("FAIL bars_px h=%0d got %h exp %h", hh, {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
        end
    endtask

    task automatic test_checker();
        mode_sel = 2'd2;
        step(0, 0, 1);
        step(32, 0, 1);
        step(32, 32, 1);
        checks++;
        if ({de, r, g, b} !== 25'h1_FFFFFF)
            begin errors++; $display("FAIL chk_white got %h exp %h", {de, r, g, b}, 25'h1_FFFFFF); end
        step(40, 40, 0);
        checks++;
        if ({de, r, g, b} !== 25'h1_000000)
            begin errors++; $display("FAIL chk_black got %h exp %h", {de, r, g, b}, 25'h1_000000); end
        step(1, 1, 1);
        checks++;
        if ({de, r, g, b} !== 25'h0)
            begin errors++; $display("FAIL chk_blank got %h exp 0", {de, r, g, b}); end
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 1200), $urandom_range(1, 900), $urandom_range(0, 3) != 0);
            checks++;
            if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                begin errors++; $display("FAIL chk_px got %h exp %h", {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
        end
    endtask

    task automatic test_mode_change();
        mode_sel = 2'd0;
        step(0, 0, 1);
        for (int i = 0; i < 80; i++) begin
            if (i == 20) mode_sel = 2'd2;
            if (i == 60) step(0, 0, 1);
            else step($urandom_range(0, 1023), (i < 20) ? 100 + i : 300 + i, 1);
            checks++;
            if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                begin errors++; $display("FAIL modechg_px i=%0d got %h exp %h", i, {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
        end
    endtask

    task automatic test_box();
        int targets[3] = '{960, 961, 1925};
        int x, y;
        reset_dut();
        mode_sel = 2'd3;
        foreach (targets[t]) begin
            while (k_m < targets[t]) begin
                step(0, 0, 1);
                step($urandom_range(1, 1023), $urandom_range(1, 767), 1);
                checks++;
                if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                    begin errors++; $display("FAIL box_frame k=%0d got %h exp %h", k_m, {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
            end
            x = tri_pos(k_m, H_RES - BOX_SIZE);
            y = tri_pos(k_m, V_RES - BOX_SIZE);
            for (int p = 0; p < 9; p++) begin
                case (p)
                    0: step(x, y, 1);
                    1: step(x + BOX_SIZE, y, 1);
                    2: step((x > 0) ? x - 1 : 0, y, 1);
                    3: step(x + BOX_SIZE - 1, y + BOX_SIZE - 1, 1);
                    4: step(x, y + BOX_SIZE, 1);
                    5: step(x + 10, (y > 0) ? y - 1 : 0, 1);
                    default: step($urandom_range(0, 1023), $urandom_range(1, 767), 1);
                endcase
                checks++;
                if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                    begin errors++; $display("FAIL box_probe k=%0d p=%0d got %h exp %h", k_m, p, {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
            end
        end
    endtask

    task automatic test_reset_midline();
        mode_sel = 2'd2;
        step(0, 0, 1);
        for (int i = 1; i < 6; i++) step(40 + i, 7, 1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mode_cur, de, r, g, b} !== '0)
            begin errors++; $display("FAIL midline_reset got %h exp 0", {mode_cur, de, r, g, b}); end
        @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 40; i++) begin
            if (i == 20) step(0, 0, 1);
            else step(100 + i, 7, 1);
            checks++;
            if ({mode_cur, de, r, g, b} !== {mode_m, out_exp})
                begin errors++; $display("FAIL midline_resume i=%0d got %h exp %h", i, {mode_cur, de, r, g, b}, {mode_m, out_exp}); end
        end
    endtask

    initial begin
        test_reset();
        test_gamut();
        test_bars();
        test_checker();
        test_mode_change();
        test_box();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
